// File: rtl/weight_fifo_ctrl.sv
// weight_fifo_ctrl: fetches one weight tile from SRAM into the per-column
// weight FIFO, holds it until the array asks for it, then drains it row by row.
//
// state | meaning
// IDLE  | waiting for start; done pulse (if any) is shown here
// FILL  | FIFO_DEPTH SRAM reads plus one trailing write cycle
// READY | full tile held in the FIFO, waiting for load_req
// DRAIN | one row per cycle to the array, zeros shifted in behind
module weight_fifo_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_INPUTS = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    input  logic [FIFO_INPUTS-1:0]            col_mask,
    input  logic                              abort,
    output logic                              mem_rd_en,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    input  logic [DATA_WIDTH*FIFO_INPUTS-1:0] mem_rd_data,
    output logic [FIFO_INPUTS-1:0]            fifo_en,
    output logic [DATA_WIDTH*FIFO_INPUTS-1:0] fifo_weight_in,
    input  logic                              load_req,
    output logic                              array_load,
    output logic                              weights_ready,
    output logic                              busy,
    output logic                              done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FILL, READY, DRAIN} stateT;

    stateT                  state, nextState;
    logic [CNT_W-1:0]       cnt;
    logic [ADDR_WIDTH-1:0]  addrReg;
    logic [FIFO_INPUTS-1:0] maskReg;
    logic                   rdValid;
    logic                   doneReg;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and output decode; abort overrides every transition
    always_comb begin
        nextState      = state;
        mem_rd_en      = 1'b0;
        mem_addr       = '0;
        fifo_en        = '0;
        fifo_weight_in = '0;
        array_load     = 1'b0;
        weights_ready  = 1'b0;
        busy           = (state != IDLE);
        done           = doneReg;
        case (state)
            IDLE: begin
                if (start) nextState = FILL;
            end
            FILL: begin
                if (cnt != '0) begin
                    mem_rd_en = 1'b1;
                    mem_addr  = addrReg;
                end else begin
                    nextState = READY;
                end
                if (rdValid) begin
                    fifo_en        = maskReg;
                    fifo_weight_in = mem_rd_data;
                end
            end
            READY: begin
                weights_ready = 1'b1;
                if (load_req) nextState = DRAIN;
            end
            DRAIN: begin
                array_load = 1'b1;
                fifo_en    = maskReg;
                if (cnt == '0) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        if (abort) nextState = IDLE;
    end

    // Tile parameters, down-counter, read-valid pipe and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            addrReg <= '0;
            maskReg <= '0;
            rdValid <= 1'b0;
            doneReg <= 1'b0;
        end else if (abort) begin
            cnt     <= '0;
            rdValid <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            rdValid <= mem_rd_en;
            doneReg <= (state == DRAIN) && (cnt == '0);
            case (state)
                IDLE: begin
                    if (start) begin
                        addrReg <= base_addr;
                        maskReg <= col_mask;
                        cnt     <= CNT_W'(FIFO_DEPTH);
                    end
                end
                FILL: begin
                    if (cnt != '0) begin
                        cnt     <= cnt - CNT_W'(1);
                        addrReg <= addrReg + ADDR_WIDTH'(1);
                    end
                end
                READY: begin
                    if (load_req) cnt <= CNT_W'(FIFO_DEPTH - 1);
                end
                DRAIN: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fifo_ctrl.sv
// Testbench for weight_fifo_ctrl: directed tile sequences plus random traffic,
// compared every cycle against a phase/step reference model and a FIFO model.
module tb_weight_fifo_ctrl;

    localparam int DW = 8;
    localparam int FI = 4;
    localparam int FD = 4;
    localparam int AW = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [AW-1:0]  baseAddr = '0;
    logic [FI-1:0]  colMask = '0;
    logic           abort = 1'b0;
    logic           memRdEn;
    logic [AW-1:0]  memAddr;
    logic [DW*FI-1:0] memRdData = '0;
    logic [FI-1:0]  fifoEn;
    logic [DW*FI-1:0] fifoWeightIn;
    logic           loadReq = 1'b0;
    logic           arrayLoad;
    logic           weightsReady;
    logic           busy;
    logic           done;

    int checks = 0;
    int fails  = 0;

    // Reference model: phase 0 idle, 1 fill, 2 ready, 3 drain; step counts cycles in phase
    int          mPhase = 0;
    int          mStep  = 0;
    logic [7:0]  mBase  = '0;
    logic [3:0]  mMask  = '0;
    logic        mDone  = 1'b0;
    logic [7:0]  fifoM [FI][FD];

    weight_fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_INPUTS(FI), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(baseAddr), .col_mask(colMask),
        .abort(abort), .mem_rd_en(memRdEn), .mem_addr(memAddr), .mem_rd_data(memRdData),
        .fifo_en(fifoEn), .fifo_weight_in(fifoWeightIn), .load_req(loadReq),
        .array_load(arrayLoad), .weights_ready(weightsReady), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW*FI-1:0] rowOf(input logic [7:0] r);
        logic [DW*FI-1:0] v;
        for (int c = 0; c < FI; c++) v[c*DW +: DW] = r + 8'(c);
        return v;
    endfunction

    // SRAM model: one-cycle read latency, garbage when not read
    always @(posedge clk) begin
        if (memRdEn) memRdData <= rowOf(memAddr);
        else         memRdData <= $urandom;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_rd"},   32'(memRdEn), 0);
        checkVal({tag, "_addr"}, 32'(memAddr), 0);
        checkVal({tag, "_en"},   32'(fifoEn), 0);
        checkVal({tag, "_win"},  fifoWeightIn, 0);
        checkVal({tag, "_ld"},   32'(arrayLoad), 0);
        checkVal({tag, "_rdy"},  32'(weightsReady), 0);
        checkVal({tag, "_busy"}, 32'(busy), 0);
        checkVal({tag, "_done"}, 32'(done), 0);
    endtask

    // One clock cycle: check outputs, apply inputs, update models
    task automatic step(input logic st, input logic ab, input logic ld,
                        input logic [7:0] b, input logic [3:0] m);
        logic        fillRead, fillWrite;
        logic [7:0]  expAddr;
        @(negedge clk);
        fillRead  = (mPhase == 1) && (mStep < FD);
        fillWrite = (mPhase == 1) && (mStep >= 1);
        expAddr   = mBase + 8'(mStep);
        checkVal("mem_rd_en", 32'(memRdEn), 32'(fillRead));
        checkVal("mem_addr",  32'(memAddr), fillRead ? 32'(expAddr) : 0);
        checkVal("fifo_en",   32'(fifoEn), (fillWrite || mPhase == 3) ? 32'(mMask) : 0);
        checkVal("fifo_win",  fifoWeightIn, fillWrite ? memRdData : 0);
        checkVal("array_load", 32'(arrayLoad), 32'(mPhase == 3));
        checkVal("weights_ready", 32'(weightsReady), 32'(mPhase == 2));
        checkVal("busy", 32'(busy), 32'(mPhase != 0));
        checkVal("done", 32'(done), 32'(mDone));
        if (mPhase == 3) begin
            for (int c = 0; c < FI; c++)
                if (mMask[c]) checkVal("array_row", 32'(fifoM[c][FD-1]), 32'(8'(mBase + 8'(mStep) + 8'(c))));
        end
        for (int c = 0; c < FI; c++) begin
            if (fifoEn[c]) begin
                for (int s = FD - 1; s > 0; s--) fifoM[c][s] = fifoM[c][s-1];
                fifoM[c][0] = fifoWeightIn[c*DW +: DW];
            end
        end
        start = st; abort = ab; loadReq = ld; baseAddr = b; colMask = m;
        mDone = 1'b0;
        if (ab) begin
            mPhase = 0; mStep = 0;
        end else begin
            case (mPhase)
                0: if (st) begin mPhase = 1; mStep = 0; mBase = b; mMask = m; end
                1: if (mStep == FD) begin mPhase = 2; mStep = 0; end else mStep++;
                2: if (ld) begin mPhase = 3; mStep = 0; end
                default: if (mStep == FD - 1) begin mPhase = 0; mStep = 0; mDone = 1'b1; end
                         else mStep++;
            endcase
        end
    endtask

    task automatic idleN(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    endtask

    initial begin
        for (int c = 0; c < FI; c++) for (int s = 0; s < FD; s++) fifoM[c][s] = '0;
        #12;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Fill then hold READY 10 cycles, then drain
        step(1'b1, 1'b0, 1'b0, 8'h10, 4'hF);
        idleN(5 + 10);
        step(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
        idleN(6);

        // Address wrap with a sparse mask
        step(1'b1, 1'b0, 1'b0, 8'hFE, 4'b0101);
        idleN(7);
        step(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
        idleN(6);

        // Abort on fill cycle 2, then restart immediately
        step(1'b1, 1'b0, 1'b0, 8'h40, 4'hF);
        idleN(2);
        step(1'b0, 1'b1, 1'b0, 8'h00, 4'h0);
        step(1'b1, 1'b0, 1'b0, 8'h50, 4'b0011);
        idleN(6);
        step(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);

        // Back-to-back: starts during drain/fill/ready ignored, start on the done cycle taken
        step(1'b1, 1'b0, 1'b0, 8'h99, 4'hF);
        idleN(3);
        step(1'b1, 1'b0, 1'b0, 8'h20, 4'hF);
        step(1'b1, 1'b0, 1'b0, 8'h77, 4'h1);
        idleN(5);
        step(1'b1, 1'b0, 1'b0, 8'h88, 4'h2);
        step(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
        idleN(6);

        // col_mask = 0 still runs full sequence; abort+start in IDLE drops start
        step(1'b1, 1'b0, 1'b0, 8'h30, 4'h0);
        idleN(5);
        step(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
        idleN(5);
        step(1'b1, 1'b1, 1'b0, 8'h31, 4'hF);
        idleN(2);

        // Async reset mid-DRAIN
        step(1'b1, 1'b0, 1'b0, 8'h60, 4'hF);
        idleN(5);
        step(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
        idleN(2);
        #2 reset = 1'b1;
        #1 checkAllZero("reset_drain");
        @(negedge clk);
        reset = 1'b0;
        mPhase = 0; mStep = 0; mDone = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h70, 4'hF);
        idleN(5);
        step(1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
        idleN(6);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) == 0), b, 4'($urandom));
        end
        idleN(2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
